// File: rtl/ahb_reg_slave.sv
// AHB-lite slave with a bank of NREGS 32-bit registers, WAIT wait states and byte-lane writes.
// Define AHB_REG_SLAVE_ERR_EN to build the two-cycle ERROR response for illegal accesses.
module ahb_reg_slave #(
  parameter int NREGS = 8,
  parameter int WAIT  = 1
) (
  input  logic                HCLK_I,
  input  logic                HRESET_I,
  input  logic                HSEL_I,
  input  logic [31:0]         HADDR_I,
  input  logic [1:0]          HTRANS_I,
  input  logic                HWRITE_I,
  input  logic [2:0]          HSIZE_I,
  input  logic [31:0]         HWDATA_I,
  input  logic                HREADY_I,
  output logic                HREADYOUT_O,
  output logic                HRESP_O,
  output logic [31:0]         HRDATA_O,
  output logic [32*NREGS-1:0] REGS_O
);
  localparam int IDX_W = (NREGS > 1) ? $clog2(NREGS) : 1;

`ifdef AHB_REG_SLAVE_ERR_EN
  typedef enum logic [2:0] {S_IDLE, S_WAITST, S_DONE, S_ERR1, S_ERR2} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_WAITST, S_DONE} state_t;
`endif

  state_t state_q, state_d, first_state;

  logic [31:0]      regs [NREGS];
  logic [IDX_W-1:0] idx_p0;
  logic             wr_p0;
  logic             ok_p0;
  logic [3:0]       mask_p0;
  logic [3:0]       cnt_p0;

  logic       accept;
  logic       in_range;
  logic       size_ok;
  logic [1:0] lo_al;
  logic [3:0] mask_ap;
  logic       we;
  logic       rd_en;
  logic       unused_bits;

  assign unused_bits = &{1'b0, HADDR_I[31:12], HTRANS_I[0]};

  // Address phase decode; lo_al is the address forced down to the size alignment
  always_comb begin
    accept   = HSEL_I & HREADY_I & HTRANS_I[1] & HREADYOUT_O;
    in_range = {22'd0, HADDR_I[11:2]} < 32'(NREGS);
    size_ok  = HSIZE_I <= 3'd2;
    case (HSIZE_I)
      3'd1:    lo_al = {HADDR_I[1], 1'b0};
      3'd2:    lo_al = 2'b00;
      default: lo_al = HADDR_I[1:0];
    endcase
    case (HSIZE_I)
      3'd0:    mask_ap = 4'b0001 << lo_al;
      3'd1:    mask_ap = 4'b0011 << lo_al;
      3'd2:    mask_ap = 4'b1111;
      default: mask_ap = 4'b0000;
    endcase
    first_state = (WAIT > 0) ? S_WAITST : S_DONE;
`ifdef AHB_REG_SLAVE_ERR_EN
    if (!(in_range && size_ok && (lo_al == HADDR_I[1:0]))) first_state = S_ERR1;
`endif
  end

  always_ff @(posedge HCLK_I) begin
    if (HRESET_I) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: state_d = accept ? first_state : S_IDLE;
      S_WAITST:       if (cnt_p0 == 4'(WAIT - 1)) state_d = S_DONE;
`ifdef AHB_REG_SLAVE_ERR_EN
      S_ERR1:         state_d = S_ERR2;
      S_ERR2:         state_d = accept ? first_state : S_IDLE;
`endif
      default:        state_d = S_IDLE;
    endcase
  end

  always_comb begin
    HREADYOUT_O = 1'b1;
    HRESP_O     = 1'b0;
    we          = 1'b0;
    rd_en       = 1'b0;
    case (state_q)
      S_WAITST: HREADYOUT_O = 1'b0;
      S_DONE: begin
        we    = wr_p0 & ok_p0;
        rd_en = ~wr_p0 & ok_p0;
      end
`ifdef AHB_REG_SLAVE_ERR_EN
      S_ERR1: begin
        HREADYOUT_O = 1'b0;
        HRESP_O     = 1'b1;
      end
      S_ERR2: HRESP_O = 1'b1;
`endif
      default: ;
    endcase
    HRDATA_O = rd_en ? regs[idx_p0] : 32'd0;
  end

  // Stage p0: captured address phase, held through the data phase
  always_ff @(posedge HCLK_I) begin
    if (HRESET_I) begin
      cnt_p0  <= 4'd0;
      idx_p0  <= '0;
      wr_p0   <= 1'b0;
      ok_p0   <= 1'b0;
      mask_p0 <= 4'd0;
    end else begin
      cnt_p0 <= (state_q == S_WAITST) ? cnt_p0 + 4'd1 : 4'd0;
      if (accept) begin
        idx_p0  <= HADDR_I[IDX_W+1:2];
        wr_p0   <= HWRITE_I;
        ok_p0   <= in_range & size_ok;
        mask_p0 <= mask_ap;
      end
    end
  end

  // Write commits on the edge that ends DONE, lane by lane
  always_ff @(posedge HCLK_I) begin
    for (int i = 0; i < NREGS; i++) begin
      if (HRESET_I) begin
        regs[i] <= 32'd0;
      end else if (we && (idx_p0 == IDX_W'(i))) begin
        for (int b = 0; b < 4; b++) begin
          if (mask_p0[b]) regs[i][8*b +: 8] <= HWDATA_I[8*b +: 8];
        end
      end
    end
  end

  for (genvar g = 0; g < NREGS; g++) begin : g_regs
    assign REGS_O[32*g +: 32] = regs[g];
  end

endmodule

// File: tb/tb_ahb_reg_slave.sv
// Scoreboard bench for ahb_reg_slave: three instances (WAIT=1, 0, 3) share one bus driver.
`timescale 1ns/1ps
module tb_ahb_reg_slave;
`ifdef AHB_REG_SLAVE_ERR_EN
  localparam bit ERR = 1'b1;
`else
  localparam bit ERR = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        hreset, hsel, hwrite;
  logic [31:0] haddr, hwdata;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic [1:0]  cur;
  logic        mon_en;

  logic        rdy0, rdy1, rdy2, resp0, resp1, resp2;
  logic [31:0] rd0, rd1, rd2;
  logic [255:0] regs0, regs1, regs2;
  logic        rdy_c, resp_c;
  logic [31:0] rdata_c;

  ahb_reg_slave #(.NREGS(8), .WAIT(1)) dut0 (
    .HCLK_I(clk), .HRESET_I(hreset), .HSEL_I(hsel && cur == 2'd0), .HADDR_I(haddr),
    .HTRANS_I(htrans), .HWRITE_I(hwrite), .HSIZE_I(hsize), .HWDATA_I(hwdata),
    .HREADY_I(rdy_c), .HREADYOUT_O(rdy0), .HRESP_O(resp0), .HRDATA_O(rd0), .REGS_O(regs0));
  ahb_reg_slave #(.NREGS(8), .WAIT(0)) dut1 (
    .HCLK_I(clk), .HRESET_I(hreset), .HSEL_I(hsel && cur == 2'd1), .HADDR_I(haddr),
    .HTRANS_I(htrans), .HWRITE_I(hwrite), .HSIZE_I(hsize), .HWDATA_I(hwdata),
    .HREADY_I(rdy_c), .HREADYOUT_O(rdy1), .HRESP_O(resp1), .HRDATA_O(rd1), .REGS_O(regs1));
  ahb_reg_slave #(.NREGS(8), .WAIT(3)) dut2 (
    .HCLK_I(clk), .HRESET_I(hreset), .HSEL_I(hsel && cur == 2'd2), .HADDR_I(haddr),
    .HTRANS_I(htrans), .HWRITE_I(hwrite), .HSIZE_I(hsize), .HWDATA_I(hwdata),
    .HREADY_I(rdy_c), .HREADYOUT_O(rdy2), .HRESP_O(resp2), .HRDATA_O(rd2), .REGS_O(regs2));

  always_comb begin
    case (cur)
      2'd1:    begin rdy_c = rdy1; resp_c = resp1; rdata_c = rd1; end
      2'd2:    begin rdy_c = rdy2; resp_c = resp2; rdata_c = rd2; end
      default: begin rdy_c = rdy0; resp_c = resp0; rdata_c = rd0; end
    endcase
  end

  function automatic logic [255:0] regs_of(input int k);
    case (k)
      1:       return regs1;
      2:       return regs2;
      default: return regs0;
    endcase
  endfunction

  function automatic logic [31:0] reg_of(input int k, input int i);
    logic [255:0] v;
    v = regs_of(k);
    return v[32*i +: 32];
  endfunction

  function automatic logic [2:0] outs_of(input int k);
    case (k)
      1:       return {rdy1, resp1, |rd1};
      2:       return {rdy2, resp2, |rd2};
      default: return {rdy0, resp0, |rd0};
    endcase
  endfunction

  typedef struct {
    int          waits;
    logic        resp;
    logic [31:0] rdata;
  } exp_t;
  exp_t sb[$];

  int n_vec = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issue one transfer at posedge+1; returns at posedge+1 after it was accepted
  task automatic xfer(input bit w, input logic [31:0] a, input logic [2:0] sz,
                      input logic [31:0] wd, input int ew, input logic er, input logic [31:0] erd);
    exp_t e;
    int n = 0;
    hsel = 1'b1; htrans = 2'b10; hwrite = w; haddr = a; hsize = sz;
    e.waits = ew; e.resp = er; e.rdata = erd;
    sb.push_back(e);
    @(negedge clk);
    while (!rdy_c && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("addr_phase_timeout", rdy_c, 1'b1);
    @(posedge clk); #1;
    hsel = 1'b0; htrans = 2'b00; hwdata = wd;
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic realign();
    @(posedge clk); #1;
  endtask

  initial begin : monitor
    bit   in_dp;
    int   waits;
    exp_t e;
    in_dp = 1'b0;
    waits = 0;
    forever begin
      @(negedge clk);
      if (!mon_en || hreset) begin
        in_dp = 1'b0;
      end else begin
        if (in_dp) begin
          if (!rdy_c) begin
            waits++;
            if (sb.size() > 0) chk("stall_hresp", resp_c, sb[0].resp);
            if (waits > 20) begin
              chk("data_phase_timeout", rdy_c, 1'b1);
              in_dp = 1'b0;
              if (sb.size() > 0) void'(sb.pop_front());
            end
          end else begin
            in_dp = 1'b0;
            if (sb.size() == 0) begin
              chk("unexpected_response", 32'(sb.size()), 32'd1);
            end else begin
              e = sb.pop_front();
              chk("wait_cycles", 32'(waits), 32'(e.waits));
              chk("hresp", resp_c, e.resp);
              chk("hrdata", rdata_c, e.rdata);
            end
          end
        end
        if (hsel && htrans[1] && rdy_c) begin
          in_dp = 1'b1;
          waits = 0;
        end
      end
    end
  end

  initial begin
    hreset = 1'b1; hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0;
    haddr = '0; hsize = 3'd0; hwdata = '0; cur = 2'd0; mon_en = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("reset_ready_resp_rdata", outs_of(k), 3'b100);
      chk("reset_regs", regs_of(k), '0);
    end
    realign();
    hreset = 1'b0;

    // WAIT=1: word write/read, then byte and halfword lane writes
    cur = 2'd0;
    xfer(1'b1, 32'h4, 3'd2, 32'hDEADBEEF, 1, 1'b0, 32'h0);
    xfer(1'b0, 32'h4, 3'd2, 32'h0,        1, 1'b0, 32'hDEADBEEF);
    settle(3);
    chk("regs_word_write", reg_of(0, 1), 32'hDEADBEEF);
    realign();
    xfer(1'b1, 32'h6, 3'd0, 32'h11AA2233, 1, 1'b0, 32'h0);
    settle(3);
    chk("regs_byte_write", reg_of(0, 1), 32'hDEAABEEF);
    realign();
    xfer(1'b1, 32'h6, 3'd1, 32'h1234FFFF, 1, 1'b0, 32'h0);
    xfer(1'b0, 32'h4, 3'd2, 32'h0,        1, 1'b0, 32'h1234BEEF);
    settle(3);
    chk("regs_half_write", reg_of(0, 1), 32'h1234BEEF);
    realign();

    // IDLE, BUSY and unselected NONSEQ must not be captured
    for (int k = 0; k < 3; k++) begin
      hsel = (k != 2); htrans = (k == 0) ? 2'b00 : (k == 1) ? 2'b01 : 2'b10;
      hwrite = 1'b1; haddr = 32'h4; hsize = 3'd2;
      realign();
      hsel = 1'b0; htrans = 2'b00; hwdata = 32'hFFFFFFFF;
      @(negedge clk);
      chk("uncaptured_ready", rdy_c, 1'b1);
      settle(1);
      chk("uncaptured_nowrite", reg_of(0, 1), 32'h1234BEEF);
      realign();
    end

    // WAIT=0 pipelined write/read pairs with no stalls
    cur = 2'd1;
    xfer(1'b1, 32'h0, 3'd2, 32'h11, 0, 1'b0, 32'h0);
    xfer(1'b0, 32'h0, 3'd2, 32'h0,  0, 1'b0, 32'h11);
    xfer(1'b1, 32'h0, 3'd2, 32'h22, 0, 1'b0, 32'h0);
    xfer(1'b0, 32'h0, 3'd2, 32'h0,  0, 1'b0, 32'h22);
    settle(3);
    chk("regs_pipelined", reg_of(1, 0), 32'h22);
    realign();

    // Illegal accesses: out of range, misaligned word, size 3
    cur = 2'd0;
    xfer(1'b0, 32'h20, 3'd2, 32'h0,        1, ERR,  32'h0);
    xfer(1'b1, 32'h2,  3'd2, 32'hCAFEF00D, 1, ERR,  32'h0);
    xfer(1'b0, 32'h0,  3'd3, 32'h0,        1, ERR,  32'h0);
    xfer(1'b0, 32'h0,  3'd2, 32'h0,        1, 1'b0, ERR ? 32'h0 : 32'hCAFEF00D);
    settle(3);
    chk("illegal_then_idle", {rdy_c, resp_c}, 2'b10);
    chk("regs_misaligned_write", reg_of(0, 0), ERR ? 32'h0 : 32'hCAFEF00D);
    realign();

    // WAIT=3 write, then reset during WAITST of a second write
    cur = 2'd2;
    xfer(1'b1, 32'h4, 3'd2, 32'hA5A5A5A5, 3, 1'b0, 32'h0);
    settle(6);
    chk("regs_wait3_write", reg_of(2, 1), 32'hA5A5A5A5);
    realign();
    mon_en = 1'b0;
    hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = 32'h0; hsize = 3'd2;
    realign();
    hsel = 1'b0; htrans = 2'b00; hwdata = 32'h12345678;
    @(negedge clk);
    chk("waitst_ready_low", rdy_c, 1'b0);
    realign();
    hreset = 1'b1;
    realign();
    hreset = 1'b0;
    @(negedge clk);
    chk("midreset_ready_resp_rdata", outs_of(2), 3'b100);
    chk("midreset_regs", regs_of(2), '0);
    settle(6);
    chk("midreset_write_dropped", regs_of(2), '0);
    chk("scoreboard_leftover", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule

// File: doc/ahb_reg_slave.md
# ahb_reg_slave

AHB-lite slave exposing a bank of 32-bit read/write registers, with configurable wait states and byte-lane writes. It is the responder at the far end of the system AHB-lite interconnect. It takes its select from the address decoder and returns HREADYOUT/HRESP/HRDATA to the response mux's per-slave inputs. Register contents are exported in parallel for use as control registers by peripherals.

## Interface

- NREGS, 8, number of 32-bit registers (1..1024), at byte offsets 4*i within the slave's 4 KB window
- WAIT, 1, wait states inserted in every OKAY data phase (0..15)
- HCLK_I  input  1  bus clock; all logic on rising edge
- HRESET_I  input  1  synchronous, active-high reset
- HSEL_I  input  1  slave select from address decoder
- HADDR_I  input  32  address; only HADDR_I[11:0] used
- HTRANS_I  input  2  transfer type; bit 1 set = NONSEQ/SEQ
- HWRITE_I  input  1  1 = write
- HSIZE_I  input  3  0 byte, 1 halfword, 2 word; others illegal
- HWDATA_I  input  32  write data, valid in data phase
- HREADY_I  input  1  system ready (address phase qualifier)
- HREADYOUT_O  output  1  slave ready
- HRESP_O  output  1  1 = ERROR
- HRDATA_O  output  32  read data
- REGS_O  output  32*NREGS  register i on bits [32*i+31:32*i]

## Operation

- Accept an address phase when HSEL_I & HREADY_I & HTRANS_I[1] on a rising edge. Capture index = HADDR_I[11:2], HWRITE_I, and the byte-lane mask.
- Byte lanes are little-endian. Byte: lane HADDR_I[1:0]. Halfword: lanes {2a+1,2a} with a = HADDR_I[1]. Word: all four lanes.
- An access is illegal if index >= NREGS, HSIZE_I > 2, or it is misaligned (halfword with HADDR_I[0]=1, word with HADDR_I[1:0]≠0).
- IDLE/BUSY transfers, or HSEL_I low with HREADY_I high, are not captured. The slave keeps or returns HREADYOUT_O=1 and HRESP_O=0.
- FSM states:
  - IDLE → WAITST when a legal transfer is accepted and WAIT>0.
  - IDLE → DONE when a legal transfer is accepted and WAIT=0.
  - IDLE → ERR1 when an illegal transfer is accepted (see Configuration).
  - WAITST counts WAIT cycles, then → DONE.
  - ERR1 → ERR2.
  - DONE and ERR2 → IDLE, or directly into the next transfer if a new address phase is accepted in that same cycle (pipelined back-to-back).
- Writes: selected lanes of HWDATA_I are written to the register at the rising edge ending DONE. Unselected lanes are unchanged.
- Reads: during DONE, HRDATA_O = register[index]. Otherwise HRDATA_O = 0.
- REGS_O reflects register contents combinationally from the register flops.

## Timing

- Reset values: all registers 0, REGS_O=0, HREADYOUT_O=1, HRESP_O=0, HRDATA_O=0, FSM=IDLE.
- Reset asserted mid-transfer aborts it; a pending write is dropped.
- OKAY data phase lasts WAIT+1 cycles: HREADYOUT_O=0 for WAIT cycles, then 1 for one cycle (DONE).
- ERROR response takes two cycles and incurs no wait states:
  - ERR1: HRESP_O=1, HREADYOUT_O=0.
  - ERR2: HRESP_O=1, HREADYOUT_O=1.
  - No register is written for an erroring access.
- Write then read of the same register back-to-back: the read returns the newly written value, because the write commits at the end of the write's data phase, before the read's DONE.
- An address phase presented while the slave is in WAITST or ERR1 is not captured, since HREADY_I is low.
- HRESP_O=0 in all states other than ERR1 and ERR2.

## Configuration

- AHB_REG_SLAVE_ERR_EN defined: illegal accesses produce the two-cycle ERROR response described above.
- AHB_REG_SLAVE_ERR_EN undefined: ERR1/ERR2 are not built and HRESP_O is tied 0. Illegal accesses instead:
  - complete as OKAY with normal wait states;
  - write nothing and read 0 when out of range or HSIZE_I > 2;
  - when misaligned, have their address low bits masked down to the size alignment and proceed.

## Test plan

- Reset, then WAIT=1: word write 0xDEADBEEF to offset 0x4, then word read of 0x4. Write and read each show HREADYOUT_O low 1 cycle then high. Read returns 0xDEADBEEF and REGS_O[63:32]=0xDEADBEEF.
- Byte write 0xAA to offset 0x6 after the above. Register 1 = 0xDEAABEEF. Halfword write 0x1234 to 0x6 gives 0x1234BEEF.
- Back-to-back pipelined WAIT=0 sequence: write 0x11 to 0x0, read 0x0, write 0x22 to 0x0, read 0x0. Reads return 0x11 then 0x22 with no stall cycles.
- With AHB_REG_SLAVE_ERR_EN, NREGS=8: read of offset 0x20 gives HRESP_O=1/HREADYOUT_O=0, then HRESP_O=1/HREADYOUT_O=1, then IDLE. Misaligned word write to 0x2 also errors and leaves register 0 unchanged.
- Without AHB_REG_SLAVE_ERR_EN: same accesses give HRESP_O=0 throughout. Read of 0x20 returns 0. Word write 0xCAFEF00D to 0x2 lands in register 0.
- HRESET_I asserted during WAITST of a write with WAIT=3. Next cycle: HREADYOUT_O=1, HRESP_O=0, all REGS_O=0, and the write does not occur.
